// File: rtl/weight_pingpong_buffer.sv
// Two-bank ping-pong weight store. The DRAM loader fills one bank while the
// dispatcher drains the other. Bank ownership is tracked with per-bank full
// flags: a last-write hands a bank to the dispatcher, and a release hands it
// back to the loader.

// One bank of line storage, built from 16 equal-width slices that share an
// address. It has a single port, and reads are registered.
module sram16_wrapper #(
  parameter int ADDR_WIDTH  = 8,
  parameter int SLICE_WIDTH = 256
) (
  input  logic                      clk,
  input  logic                      i_en,
  input  logic                      i_we,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  input  logic [16*SLICE_WIDTH-1:0] i_wdata,
  output logic [16*SLICE_WIDTH-1:0] o_rdata
);

  for (genvar g = 0; g < 16; g++) begin : g_slice
    logic [SLICE_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [SLICE_WIDTH-1:0] r_q;

    // Slice storage: the write takes priority, otherwise a registered read.
    // The storage is not reset.
    always_ff @(posedge clk) begin
      if (i_en) begin
        if (i_we) r_mem[i_addr] <= i_wdata[g*SLICE_WIDTH +: SLICE_WIDTH];
        else      r_q           <= r_mem[i_addr];
      end
    end

    assign o_rdata[g*SLICE_WIDTH +: SLICE_WIDTH] = r_q;
  end

endmodule

module weight_pingpong_buffer #(
  parameter int DATA_WIDTH = 4096,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_dram_req,
  input  logic                  in_dram_we,
  input  logic [ADDR_WIDTH-1:0] in_dram_addr,
  input  logic [DATA_WIDTH-1:0] in_dram_wdata,
  input  logic                  in_dram_last,
  output logic                  out_dram_ready,
  input  logic                  in_disp_req,
  input  logic [ADDR_WIDTH-1:0] in_disp_addr,
  input  logic                  in_disp_release,
  output logic                  out_disp_ready,
  output logic                  out_disp_rvalid,
  output logic [DATA_WIDTH-1:0] out_disp_rdata,
  output logic                  out_fill_bank,
  output logic                  out_drain_bank,
  output logic [1:0]            out_bank_full,
  input  logic                  in_err_clr,
  output logic                  out_err
);

  // Bank ownership state
  logic       r_fill_ptr;
  logic       r_drain_ptr;
  logic [1:0] r_full;

  // Write input pipeline stage
  logic                  r_wr_vld;
  logic                  r_wr_bank;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;

  // Read pipeline: request stage, then the SRAM-access stage
  logic                  r_rd_vld;
  logic                  r_rd_bank;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_rd_vld2;
  logic                  r_rd_bank2;

  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic                  w_dram_ready;
  logic                  w_disp_ready;
  logic                  w_wr_acc;
  logic                  w_last_acc;
  logic                  w_rd_acc;
  logic                  w_rel_acc;
  logic                  w_err_set;
  logic [1:0]            w_bank_en;
  logic [1:0]            w_bank_we;
  logic [ADDR_WIDTH-1:0] w_bank_addr  [2];
  logic [DATA_WIDTH-1:0] w_bank_rdata [2];

  assign w_dram_ready = ~r_full[r_fill_ptr];
  assign w_disp_ready = r_full[r_drain_ptr];

  assign w_wr_acc   = in_dram_req & in_dram_we & w_dram_ready;
  assign w_last_acc = w_wr_acc & in_dram_last;
  assign w_rd_acc   = in_disp_req & w_disp_ready;
  assign w_rel_acc  = in_disp_release & w_disp_ready;
  assign w_err_set  = (in_dram_req & in_dram_we & ~w_dram_ready)
                    | (in_disp_req & ~w_disp_ready)
                    | (in_disp_release & ~w_disp_ready);

  // Per-bank port steering. The fill bank and the drain bank of any pipeline
  // stage never coincide, so the write/read priority here never arbitrates a
  // real conflict.
  always_comb begin
    for (int unsigned b = 0; b < 2; b++) begin
      w_bank_we[b]   = r_wr_vld & (r_wr_bank == 1'(b));
      w_bank_en[b]   = w_bank_we[b] | (r_rd_vld & (r_rd_bank == 1'(b)));
      w_bank_addr[b] = w_bank_we[b] ? r_wr_addr : r_rd_addr;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    sram16_wrapper #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .SLICE_WIDTH (DATA_WIDTH / 16)
    ) u_sram (
      .clk     (clk),
      .i_en    (w_bank_en[b]),
      .i_we    (w_bank_we[b]),
      .i_addr  (w_bank_addr[b]),
      .i_wdata (r_wr_data),
      .o_rdata (w_bank_rdata[b])
    );
  end

  // Bank ownership: a last write hands the fill bank over, and a release
  // hands the drain bank back. The two always target different banks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill_ptr  <= 1'b0;
      r_drain_ptr <= 1'b0;
      r_full      <= '0;
    end else begin
      if (w_last_acc) begin
        r_full[r_fill_ptr] <= 1'b1;
        r_fill_ptr         <= ~r_fill_ptr;
      end
      if (w_rel_acc) begin
        r_full[r_drain_ptr] <= 1'b0;
        r_drain_ptr         <= ~r_drain_ptr;
      end
    end
  end

  // Write pipeline: capture the accepted write, and commit it on the next edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_vld  <= 1'b0;
      r_wr_bank <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_vld <= w_wr_acc;
      if (w_wr_acc) begin
        r_wr_bank <= r_fill_ptr;
        r_wr_addr <= in_dram_addr;
        r_wr_data <= in_dram_wdata;
      end
    end
  end

  // Read pipeline: request capture, SRAM access, then the registered output.
  // rdata holds its value on idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_vld   <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_vld2  <= 1'b0;
      r_rd_bank2 <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_rd_vld <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_bank <= r_drain_ptr;
        r_rd_addr <= in_disp_addr;
      end
      r_rd_vld2  <= r_rd_vld;
      r_rd_bank2 <= r_rd_bank;
      r_rvalid   <= r_rd_vld2;
      if (r_rd_vld2) r_rdata <= w_bank_rdata[r_rd_bank2];
    end
  end

  // Sticky protocol error. A new error wins over a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_err <= 1'b0;
    else if (w_err_set)  r_err <= 1'b1;
    else if (in_err_clr) r_err <= 1'b0;
  end

  assign out_dram_ready  = w_dram_ready;
  assign out_disp_ready  = w_disp_ready;
  assign out_disp_rvalid = r_rvalid;
  assign out_disp_rdata  = r_rdata;
  assign out_fill_bank   = r_fill_ptr;
  assign out_drain_bank  = r_drain_ptr;
  assign out_bank_full   = r_full;
  assign out_err         = r_err;

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// Directed bench for weight_pingpong_buffer. Inputs change 1 time unit after
// a rising edge, and outputs are sampled at the same point.
module tb_weight_pingpong_buffer;

  localparam int DW = 4096;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dram_req = 1'b0, dram_we = 1'b0, dram_last = 1'b0;
  logic [AW-1:0] dram_addr = '0;
  logic [DW-1:0] dram_wdata = '0;
  logic          dram_ready;
  logic          disp_req = 1'b0, disp_release = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic          disp_ready, disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          fill_bank, drain_bank;
  logic [1:0]    bank_full;
  logic          err_clr = 1'b0;
  logic          err;

  int total = 0;
  int bad   = 0;

  weight_pingpong_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_dram_req     (dram_req),
    .in_dram_we      (dram_we),
    .in_dram_addr    (dram_addr),
    .in_dram_wdata   (dram_wdata),
    .in_dram_last    (dram_last),
    .out_dram_ready  (dram_ready),
    .in_disp_req     (disp_req),
    .in_disp_addr    (disp_addr),
    .in_disp_release (disp_release),
    .out_disp_ready  (disp_ready),
    .out_disp_rvalid (disp_rvalid),
    .out_disp_rdata  (disp_rdata),
    .out_fill_bank   (fill_bank),
    .out_drain_bank  (drain_bank),
    .out_bank_full   (bank_full),
    .in_err_clr      (err_clr),
    .out_err         (err)
  );

  always #5 clk = ~clk;

  // Pattern A (sel=0): byte i replicated; pattern B (sel=1): ~i replicated
  function automatic logic [DW-1:0] pat(input logic sel, input int unsigned i);
    logic [7:0] v;
    v = i[7:0];
    if (sel) v = ~v;
    return {(DW/8){v}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed[63:0]=%h expected[63:0]=%h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  int unsigned ra [3] = '{0, 100, 255};

  initial begin
    // Reset
    tick(); tick();
    rst = 1'b0;
    chk("rst_full",   32'(bank_full), 32'd0);
    chk("rst_fill",   32'(fill_bank), 32'd0);
    chk("rst_drain",  32'(drain_bank), 32'd0);
    chk("rst_dready", 32'(dram_ready), 32'd1);
    chk("rst_pready", 32'(disp_ready), 32'd0);
    chk("rst_rvalid", 32'(disp_rvalid), 32'd0);
    chkd("rst_rdata", disp_rdata, '0);
    chk("rst_err",    32'(err), 32'd0);

    // Read with no full bank
    disp_req = 1'b1; disp_addr = 8'd0;
    tick();
    disp_req = 1'b0;
    chk("rd_empty_err", 32'(err), 32'd1);
    tick(); tick();
    chk("rd_empty_rvalid", 32'(disp_rvalid), 32'd0);
    chk("rd_empty_drain",  32'(drain_bank), 32'd0);
    chk("rd_empty_fill",   32'(fill_bank), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr1", 32'(err), 32'd0);

    // Release with no full bank
    disp_release = 1'b1;
    tick();
    disp_release = 1'b0;
    chk("rel_empty_err",   32'(err), 32'd1);
    chk("rel_empty_drain", 32'(drain_bank), 32'd0);
    chk("rel_empty_full",  32'(bank_full), 32'd0);

    // Error set wins over a clear in the same cycle
    err_clr = 1'b1; disp_release = 1'b1;
    tick();
    disp_release = 1'b0;
    chk("err_set_wins", 32'(err), 32'd1);
    tick();
    err_clr = 1'b0;
    chk("err_clr2", 32'(err), 32'd0);

    // Fill bank 0 with pattern A
    dram_req = 1'b1; dram_we = 1'b1;
    for (int unsigned i = 0; i < 256; i++) begin
      dram_addr  = AW'(i);
      dram_wdata = pat(1'b0, i);
      dram_last  = (i == 255);
      tick();
    end
    dram_req = 1'b0; dram_we = 1'b0; dram_last = 1'b0;
    chk("fill0_full",   32'(bank_full), 32'd1);
    chk("fill0_fill",   32'(fill_bank), 32'd1);
    chk("fill0_pready", 32'(disp_ready), 32'd1);
    chk("fill0_dready", 32'(dram_ready), 32'd1);
    chk("fill0_drain",  32'(drain_bank), 32'd0);

    // Read bank 0 back-to-back while filling bank 1 with pattern B
    for (int unsigned c = 0; c < 258; c++) begin
      if (c < 256) begin
        disp_req = 1'b1; disp_addr = AW'(c);
        dram_req = 1'b1; dram_we = 1'b1; dram_addr = AW'(c);
        dram_wdata = pat(1'b1, c); dram_last = (c == 255);
      end else begin
        disp_req = 1'b0;
        dram_req = 1'b0; dram_we = 1'b0; dram_last = 1'b0;
      end
      tick();
      if (c < 2) begin
        chk("rd0_lat_rvalid", 32'(disp_rvalid), 32'd0);
      end else begin
        chk("rd0_rvalid", 32'(disp_rvalid), 32'd1);
        chkd("rd0_rdata", disp_rdata, pat(1'b0, c - 2));
      end
    end
    tick();
    chk("rd0_idle_rvalid", 32'(disp_rvalid), 32'd0);
    chkd("rd0_rdata_hold", disp_rdata, pat(1'b0, 255));
    chk("both_full",       32'(bank_full), 32'd3);
    chk("both_fill",       32'(fill_bank), 32'd0);
    chk("both_dready",     32'(dram_ready), 32'd0);
    chk("both_err",        32'(err), 32'd0);

    // Write attempt while both banks are full
    dram_req = 1'b1; dram_we = 1'b1; dram_addr = 8'd5; dram_wdata = '0; dram_last = 1'b1;
    tick();
    dram_req = 1'b0; dram_we = 1'b0; dram_last = 1'b0;
    chk("wr_full_err",  32'(err), 32'd1);
    chk("wr_full_full", 32'(bank_full), 32'd3);
    chk("wr_full_fill", 32'(fill_bank), 32'd0);
    disp_req = 1'b1; disp_addr = 8'd5;
    tick();
    disp_req = 1'b0;
    tick(); tick();
    chk("wr_full_rvalid", 32'(disp_rvalid), 32'd1);
    chkd("wr_full_data_kept", disp_rdata, pat(1'b0, 5));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr3", 32'(err), 32'd0);

    // Release bank 0
    disp_release = 1'b1;
    tick();
    disp_release = 1'b0;
    chk("rel0_dready", 32'(dram_ready), 32'd1);
    chk("rel0_drain",  32'(drain_bank), 32'd1);
    chk("rel0_full",   32'(bank_full), 32'd2);
    chk("rel0_pready", 32'(disp_ready), 32'd1);

    // Read bank 1 (pattern B)
    for (int unsigned c = 0; c < 5; c++) begin
      if (c < 3) begin
        disp_req = 1'b1; disp_addr = AW'(ra[c]);
      end else begin
        disp_req = 1'b0;
      end
      tick();
      if (c >= 2) begin
        chk("rd1_rvalid", 32'(disp_rvalid), 32'd1);
        chkd("rd1_rdata", disp_rdata, pat(1'b1, ra[c-2]));
      end
    end

    // Refill bank 0 with a single last write, then release bank 1
    dram_req = 1'b1; dram_we = 1'b1; dram_addr = 8'd7; dram_wdata = pat(1'b0, 8'h33); dram_last = 1'b1;
    tick();
    dram_req = 1'b0; dram_we = 1'b0; dram_last = 1'b0;
    chk("refill0_full", 32'(bank_full), 32'd3);
    chk("refill0_fill", 32'(fill_bank), 32'd1);
    disp_release = 1'b1;
    tick();
    disp_release = 1'b0;
    chk("rel1_full",  32'(bank_full), 32'd1);
    chk("rel1_drain", 32'(drain_bank), 32'd0);

    // Last write to bank 1 coinciding with release of bank 0
    dram_req = 1'b1; dram_we = 1'b1; dram_addr = 8'd9; dram_wdata = {(DW/8){8'h5A}}; dram_last = 1'b1;
    disp_release = 1'b1;
    tick();
    dram_req = 1'b0; dram_we = 1'b0; dram_last = 1'b0; disp_release = 1'b0;
    chk("coinc_full",  32'(bank_full), 32'd2);
    chk("coinc_fill",  32'(fill_bank), 32'd0);
    chk("coinc_drain", 32'(drain_bank), 32'd1);
    chk("coinc_err",   32'(err), 32'd0);

    // Earliest read of the just-filled bank sees the committed last write
    disp_req = 1'b1; disp_addr = 8'd9;
    tick();
    disp_req = 1'b0;
    tick(); tick();
    chk("early_rd_rvalid", 32'(disp_rvalid), 32'd1);
    chkd("early_rd_rdata", disp_rdata, {(DW/8){8'h5A}});

    // Reset in the middle of a 4-read burst
    for (int unsigned c = 0; c < 3; c++) begin
      disp_req = 1'b1; disp_addr = AW'(c);
      tick();
    end
    chk("burst_rvalid", 32'(disp_rvalid), 32'd1);
    chkd("burst_rdata", disp_rdata, pat(1'b1, 0));
    disp_addr = 8'd3;
    rst = 1'b1;
    #1;
    chk("arst_rvalid", 32'(disp_rvalid), 32'd0);
    chk("arst_full",   32'(bank_full), 32'd0);
    chk("arst_fill",   32'(fill_bank), 32'd0);
    chk("arst_drain",  32'(drain_bank), 32'd0);
    disp_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_dready", 32'(dram_ready), 32'd1);
    chk("post_rst_pready", 32'(disp_ready), 32'd0);
    chk("post_rst_rvalid", 32'(disp_rvalid), 32'd0);
    chk("post_rst_err",    32'(err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/weight_pingpong_buffer.md
# weight_pingpong_buffer

Double-buffered (ping-pong) weight store between the DRAM loader and the dispatcher. It is the parametrised successor of the single-bank weight buffer: data width and depth are parameters, and there are two banks. DRAM fills one bank while the dispatcher reads the other. Bank ownership is tracked with per-bank full flags and a last/release handshake, so weight prefetch for layer N+1 overlaps compute on layer N.

## Interface
- DATA_WIDTH, 4096, bits per weight line.
- ADDR_WIDTH, 8, line address width; each bank holds 2^ADDR_WIDTH lines.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_dram_req  in  1  DRAM write request.
- in_dram_we  in  1  write enable; a request with we=0 is ignored.
- in_dram_addr  in  ADDR_WIDTH  line address within the fill bank.
- in_dram_wdata  in  DATA_WIDTH  write data.
- in_dram_last  in  1  qualifies the final write of a bank fill.
- out_dram_ready  out  1  fill bank can accept writes: !bank_full[fill_ptr].
- in_disp_req  in  1  dispatcher read request.
- in_disp_addr  in  ADDR_WIDTH  line address within the drain bank.
- in_disp_release  in  1  one-cycle pulse; dispatcher is done with the drain bank.
- out_disp_ready  out  1  drain bank readable: bank_full[drain_ptr].
- out_disp_rvalid  out  1  out_disp_rdata is valid this cycle.
- out_disp_rdata  out  DATA_WIDTH  read data.
- out_fill_bank  out  1  fill_ptr.
- out_drain_bank  out  1  drain_ptr.
- out_bank_full  out  2  per-bank full flags.
- in_err_clr  in  1  clears out_err.
- out_err  out  1  sticky protocol error.

## Operation
- Each bank is one `sram16_wrapper` instance (ADDR_WIDTH, DATA_WIDTH/16) with its own port, so bank 0 and bank 1 can be written and read in the same cycle.
- State: fill_ptr, drain_ptr, bank_full[1:0]. Per bank, the cycle runs EMPTY (full=0, owned by DRAM) -> FULL (full=1, owned by dispatcher) -> EMPTY.
- Write acceptance, evaluated at the clock edge: in_dram_req & in_dram_we & out_dram_ready.
  - An accepted write is captured into the input pipeline register, together with bank=fill_ptr.
  - The SRAM write to that bank occurs on the next edge.
- Accepted write with in_dram_last=1: set bank_full[fill_ptr] and toggle fill_ptr on the same edge.
- Read acceptance: in_disp_req & out_disp_ready.
  - The address and bank=drain_ptr are captured into the input pipeline register.
  - The SRAM read occurs on the next edge.
  - The result is registered into out_disp_rdata with out_disp_rvalid=1.
  - Non-accepted cycles give rvalid=0, and rdata holds its last value.
- in_disp_release with out_disp_ready=1: clear bank_full[drain_ptr] and toggle drain_ptr.
  - The release may coincide with a read; that read completes normally.
  - Release has no effect on reads already in flight.
- A last-write and a release on the same edge always target different banks, because the fill bank is empty and the drain bank is full. Both take effect.
- out_err sets (and stays set) on any of these:
  - a DRAM request with we=1 while out_dram_ready=0;
  - a dispatcher request while out_disp_ready=0;
  - a release while out_disp_ready=0.
- The offending request is dropped. in_err_clr clears out_err; if a new error occurs in the same cycle, the set wins.
- Address wrap-around is not applicable: addresses are bank-local, and any value 0..2^ADDR_WIDTH-1 is legal. The fill order is arbitrary, and the fill length is defined solely by in_dram_last.

## Timing
- Reset values:
  - fill_ptr=0, drain_ptr=0, bank_full=2'b00;
  - out_dram_ready=1, out_disp_ready=0;
  - out_disp_rvalid=0, out_disp_rdata=0, out_err=0;
  - all pipeline registers 0.
- SRAM contents are not reset.
- Read latency is 3 edges: a request accepted at edge E gives rvalid/rdata after edge E+2, visible in the cycle following E+2. Back-to-back reads run at 1 line per cycle.
- A write accepted at edge E is committed to the SRAM at E+1. The last write sets bank_full at E; the earliest read of that bank is accepted at E+1 and reads the SRAM at E+2, so it always sees the committed data.
- After a last write, out_dram_ready reflects the other bank on the next cycle. If both banks are full, it stays low until a release.
- Asserting rst mid-fill or mid-read drops all in-flight operations immediately: rvalid=0 asynchronously, and both banks are marked empty.

## Test plan
- Reset, then write 256 lines to bank 0 (line i = {16{i[7:0] replicated}}, last on addr 255) -> bank_full=01, fill_bank=1, disp_ready=1. Read addr 0..255 back-to-back -> rvalid for 256 cycles starting 3 edges after the first request, each data correct.
- Overlap: fill bank 1 with pattern B while reading bank 0 -> no corruption of either bank. Release bank 0 -> drain_bank=1, and reads return pattern B.
- Both banks full -> dram_ready=0; a write attempt -> out_err=1 and the target data is unchanged. Release -> dram_ready=1 on the next cycle. in_err_clr -> out_err=0.
- Read or release with no full bank -> out_err=1, rvalid stays 0, and the pointers are unchanged.
- Last write to bank 1 coincident with release of bank 0 -> bank_full=10, fill_ptr=0, drain_ptr=1.
- Assert rst during a 4-read burst -> rvalid=0 immediately, bank_full=00, fill/drain=0, dram_ready=1 after release of rst.
